// File: rtl/multicycle_alu_if.sv
// Start/done request bundle for the multicycle ALU.
// The requester drives through master; the ALU receives through slave.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUCtrl;
  logic [WIDTH-1:0] inputA;
  logic [WIDTH-1:0] inputB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] resultHi;
  logic             zero;
  logic             overflow;
  logic             divZero;

  modport master (
    output start, ALUCtrl, inputA, inputB,
    input  busy, done, ALUResult, resultHi,
    input  zero, overflow, divZero
  );

  modport slave (
    input  start, ALUCtrl, inputA, inputB,
    output busy, done, ALUResult, resultHi,
    output zero, overflow, divZero
  );
endinterface

// File: rtl/multicycle_alu.sv
// EX-stage ALU: single-cycle logic/arith ops plus iterative signed mul/div.
// Define MULTICYCLE_ALU_DIV_EN to build the restoring divider (opcode 1001).
module multicycle_alu #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  multicycle_alu_if.slave bus
);
  localparam int W = WIDTH;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;
`ifdef MULTICYCLE_ALU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b1001;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   p_q, p_d;
  logic [W-1:0]     m_q, m_d;
  logic             neg_q, neg_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ov_q, ov_d;
  logic             dz_q, dz_d;

  logic           accept, multi, last;
  logic [W-1:0]   a, b, abs_a, abs_b;
  logic [W-1:0]   sum, dif, sc_res;
  logic           sc_ov;
  logic [W:0]     macc;
  logic [2*W-1:0] mstep, pnext, prod;

  assign a      = bus.inputA;
  assign b      = bus.inputB;
  assign abs_a  = a[W-1] ? -a : a;
  assign abs_b  = b[W-1] ? -b : b;
  assign accept = bus.start & (state_q != S_BUSY);
  assign last   = (state_q == S_BUSY) &&
                  (cnt_q == CNT_W'(W - 1));

`ifdef MULTICYCLE_ALU_DIV_EN
  logic           div_q, div_d;
  logic           sa_q, sa_d;
  logic [W-1:0]   rsh, quo, rem, dres, drem;
  logic [W:0]     rdif;
  logic [2*W-1:0] dstep;

  assign multi = (bus.ALUCtrl == OP_MUL) ||
                 (bus.ALUCtrl == OP_DIV);
  // Remainder stays below the divisor, so W bits hold the shifted value.
  assign rsh   = {p_q[2*W-2:W], p_q[W-1]};
  assign rdif  = {1'b0, rsh} - {1'b0, m_q};
  assign dstep = {rdif[W] ? rsh : rdif[W-1:0],
                  p_q[W-2:0], ~rdif[W]};
  assign pnext = div_q ? dstep : mstep;
  assign quo   = pnext[W-1:0];
  assign rem   = pnext[2*W-1:W];
  assign dres  = (m_q == '0) ? '1 :
                 (neg_q ? -quo : quo);
  assign drem  = sa_q ? -rem : rem;
`else
  assign multi = (bus.ALUCtrl == OP_MUL);
  assign pnext = mstep;
`endif

  assign sum   = a + b;
  assign dif   = a - b;
  assign macc  = {1'b0, p_q[2*W-1:W]} +
                 (p_q[0] ? {1'b0, m_q} : '0);
  assign mstep = {macc, p_q[W-1:1]};
  assign prod  = neg_q ? -pnext : pnext;

  always_comb begin
    sc_res = '0;
    sc_ov  = 1'b0;
    unique case (bus.ALUCtrl)
      OP_ADD: begin
        sc_res = sum;
        sc_ov  = (a[W-1] == b[W-1]) &&
                 (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ov  = (a[W-1] != b[W-1]) &&
                 (dif[W-1] != a[W-1]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_NOR: sc_res = ~(a | b);
      OP_SLT: sc_res = {{(W-1){1'b0}},
                        $signed(a) < $signed(b)};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept)
          state_d = multi ? S_BUSY : S_DONE;
      S_BUSY:
        if (last) state_d = S_DONE;
      S_DONE:
        state_d = !accept ? S_IDLE :
                  (multi ? S_BUSY : S_DONE);
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == S_BUSY);
    bus.done = (state_q == S_DONE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    p_d    = p_q;
    m_d    = m_q;
    neg_d  = neg_q;
    res_d  = res_q;
    hi_d   = hi_q;
    zero_d = zero_q;
    ov_d   = ov_q;
    dz_d   = dz_q;
`ifdef MULTICYCLE_ALU_DIV_EN
    div_d  = div_q;
    sa_d   = sa_q;
`endif
    if (accept) begin
      cnt_d = '0;
      neg_d = a[W-1] ^ b[W-1];
      m_d   = abs_a;
      p_d   = {{W{1'b0}}, abs_b};
`ifdef MULTICYCLE_ALU_DIV_EN
      div_d = (bus.ALUCtrl == OP_DIV);
      sa_d  = a[W-1];
      if (bus.ALUCtrl == OP_DIV) begin
        m_d = abs_b;
        p_d = {{W{1'b0}}, abs_a};
      end
`endif
      if (!multi) begin
        res_d  = sc_res;
        hi_d   = '0;
        zero_d = (sc_res == '0);
        ov_d   = sc_ov;
        dz_d   = 1'b0;
      end
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q + 1'b1;
      p_d   = pnext;
      if (last) begin
        res_d = prod[W-1:0];
        hi_d  = prod[2*W-1:W];
        ov_d  = 1'b0;
        dz_d  = 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
        if (div_q) begin
          res_d = dres;
          hi_d  = drem;
          dz_d  = (m_q == '0);
        end
`endif
        zero_d = (res_d == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      p_q    <= '0;
      m_q    <= '0;
      neg_q  <= 1'b0;
      res_q  <= '0;
      hi_q   <= '0;
      zero_q <= 1'b0;
      ov_q   <= 1'b0;
      dz_q   <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
      div_q  <= 1'b0;
      sa_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      m_q    <= m_d;
      neg_q  <= neg_d;
      res_q  <= res_d;
      hi_q   <= hi_d;
      zero_q <= zero_d;
      ov_q   <= ov_d;
      dz_q   <= dz_d;
`ifdef MULTICYCLE_ALU_DIV_EN
      div_q  <= div_d;
      sa_q   <= sa_d;
`endif
    end
  end

  assign bus.ALUResult = res_q;
  assign bus.resultHi  = hi_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ov_q;
  assign bus.divZero   = dz_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: arithmetic reference model checked every cycle,
// plus directed cases with literal expected values.
module tb_multicycle_alu;
  localparam int W = 32;
  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b0110;
  localparam logic [3:0] AND_ = 4'b0000;
  localparam logic [3:0] OR_  = 4'b0001;
  localparam logic [3:0] SLT  = 4'b0111;
  localparam logic [3:0] NOR_ = 4'b1100;
  localparam logic [3:0] MUL  = 4'b1000;
  localparam logic [3:0] DIV  = 4'b1001;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] h;
    logic        z;
    logic        ov;
    logic        dz;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  multicycle_alu_if #(.WIDTH(W)) bus ();
  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, need %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic out_t model(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    out_t   o;
    longint sa, sb, t;
    o  = '0;
    sa = $signed(a);
    sb = $signed(b);
    t  = 0;
    case (op)
      ADD: begin
        t    = sa + sb;
        o.r  = t[31:0];
        o.ov = (t != longint'($signed(t[31:0])));
      end
      SUB: begin
        t    = sa - sb;
        o.r  = t[31:0];
        o.ov = (t != longint'($signed(t[31:0])));
      end
      AND_: o.r = a & b;
      OR_:  o.r = a | b;
      NOR_: o.r = ~(a | b);
      SLT:  o.r = (sa < sb) ? 32'd1 : 32'd0;
      MUL: begin
        t   = sa * sb;
        o.r = t[31:0];
        o.h = t[63:32];
      end
`ifdef MULTICYCLE_ALU_DIV_EN
      DIV: begin
        if (b == 32'd0) begin
          o.r  = '1;
          o.h  = a;
          o.dz = 1'b1;
        end else begin
          t   = sa / sb;
          o.r = t[31:0];
          t   = sa % sb;
          o.h = t[31:0];
        end
      end
`endif
      default: ;
    endcase
    o.z = (o.r == 32'd0);
    return o;
  endfunction

  function automatic int lat(input logic [3:0] op);
    if (op == MUL) return W + 1;
`ifdef MULTICYCLE_ALU_DIV_EN
    if (op == DIV) return W + 1;
`endif
    return 1;
  endfunction

  // Edge index e; an op accepted at edge k completes at edge k+lat-1.
  int   e = 0;
  int   done_e = -1;
  out_t m_out = '0;
  out_t pend = '0;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e      = 0;
      done_e = -1;
      m_out  = '0;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      e = e + 1;
      if (bus.start && done_e < e) begin
        pend   = model(bus.ALUCtrl, bus.inputA, bus.inputB);
        done_e = e + lat(bus.ALUCtrl) - 1;
      end
      if (e == done_e) m_out = pend;
      m_done = (e == done_e);
      m_busy = (done_e > e);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("done", 32'(bus.done), 32'(m_done));
      check("ALUResult", bus.ALUResult, m_out.r);
      check("resultHi", bus.resultHi, m_out.h);
      check("zero", 32'(bus.zero), 32'(m_out.z));
      check("overflow", 32'(bus.overflow), 32'(m_out.ov));
      check("divZero", 32'(bus.divZero), 32'(m_out.dz));
    end
  end

  task automatic go(input logic [3:0] op,
                    input logic [31:0] a,
                    input logic [31:0] b);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.ALUCtrl = op;
    bus.inputA  = a;
    bus.inputB  = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.inputA = $urandom;
    bus.inputB = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no done in %0d cycles, need <= %0d",
               n, W + 1);
    end
  endtask

  task automatic chk_zero_outs(input string nm);
    check({nm, " busy"}, 32'(bus.busy), 32'd0);
    check({nm, " done"}, 32'(bus.done), 32'd0);
    check({nm, " res"}, bus.ALUResult, 32'd0);
    check({nm, " hi"}, bus.resultHi, 32'd0);
    check({nm, " zero"}, 32'(bus.zero), 32'd0);
    check({nm, " ov"}, 32'(bus.overflow), 32'd0);
    check({nm, " dz"}, 32'(bus.divZero), 32'd0);
  endtask

  initial begin
    int n;
    int cnt;
    logic [3:0] ops [8];
    ops = '{ADD, SUB, AND_, OR_, SLT, NOR_, MUL, DIV};
    bus.start   = 1'b0;
    bus.ALUCtrl = 4'b0000;
    bus.inputA  = '0;
    bus.inputB  = '0;
    #1 rst = 1'b1;
    #2 chk_zero_outs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    go(ADD, 32'h7FFFFFFF, 32'h1);
    wait_done(n);
    check("t1 lat", 32'(n), 32'd1);
    check("t1 res", bus.ALUResult, 32'h80000000);
    check("t1 ov", 32'(bus.overflow), 32'd1);
    check("t1 zero", 32'(bus.zero), 32'd0);

    @(negedge clk);
    bus.start   = 1'b1;
    bus.ALUCtrl = SUB;
    bus.inputA  = 32'd5;
    bus.inputB  = 32'd5;
    @(negedge clk);
    check("t2 sub done", 32'(bus.done), 32'd1);
    check("t2 sub res", bus.ALUResult, 32'd0);
    check("t2 sub zero", 32'(bus.zero), 32'd1);
    bus.ALUCtrl = SLT;
    bus.inputA  = 32'hFFFFFFFD;
    bus.inputB  = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    check("t2 slt done", 32'(bus.done), 32'd1);
    check("t2 slt res", bus.ALUResult, 32'd1);

    go(MUL, 32'hFFFFFFF9, 32'd6);
    check("t3 busy", 32'(bus.busy), 32'd1);
    wait_done(n);
    check("t3 lat", 32'(n), 32'd33);
    check("t3 lo", bus.ALUResult, 32'hFFFFFFD6);
    check("t3 hi", bus.resultHi, 32'hFFFFFFFF);

    go(MUL, 32'h80000000, 32'h80000000);
    wait_done(n);
    check("minmin lo", bus.ALUResult, 32'h0);
    check("minmin hi", bus.resultHi, 32'h40000000);

`ifdef MULTICYCLE_ALU_DIV_EN
    go(DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    check("t4 lat", 32'(n), 32'd33);
    check("t4 quo", bus.ALUResult, 32'hFFFFFFFD);
    check("t4 rem", bus.resultHi, 32'hFFFFFFFF);
    go(DIV, 32'd9, 32'd0);
    wait_done(n);
    check("div0 quo", bus.ALUResult, 32'hFFFFFFFF);
    check("div0 rem", bus.resultHi, 32'd9);
    check("div0 flag", 32'(bus.divZero), 32'd1);
    go(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    check("minm1 quo", bus.ALUResult, 32'h80000000);
    check("minm1 rem", bus.resultHi, 32'd0);
    check("minm1 ov", 32'(bus.overflow), 32'd0);
`else
    go(DIV, 32'd9, 32'd3);
    wait_done(n);
    check("t6 lat", 32'(n), 32'd1);
    check("t6 res", bus.ALUResult, 32'd0);
    check("t6 zero", 32'(bus.zero), 32'd1);
`endif

    go(SUB, 32'h80000000, 32'd1);
    wait_done(n);
    check("subov res", bus.ALUResult, 32'h7FFFFFFF);
    check("subov ov", 32'(bus.overflow), 32'd1);
    go(NOR_, 32'd0, 32'd0);
    wait_done(n);
    check("nor res", bus.ALUResult, 32'hFFFFFFFF);
    go(4'b1111, 32'd12, 32'd34);
    wait_done(n);
    check("bad op res", bus.ALUResult, 32'd0);
    check("bad op zero", 32'(bus.zero), 32'd1);

    go(MUL, 32'd1234, 32'd5678);
    repeat (3) @(negedge clk);
    bus.start   = 1'b1;
    bus.ALUCtrl = ADD;
    bus.inputA  = 32'd1;
    bus.inputB  = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("t5 busy", 32'(bus.busy), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1 chk_zero_outs("abort");
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check("t5 no done", 32'(cnt), 32'd0);
    go(ADD, 32'd2, 32'd3);
    wait_done(n);
    check("t5 add lat", 32'(n), 32'd1);
    check("t5 add res", bus.ALUResult, 32'd5);

    for (int i = 0; i < 10; i++) begin
      go(ops[$urandom_range(0, 7)], $urandom, $urandom);
      wait_done(n);
    end
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
